dbus_ram_responder: RTL and testbench

DBUS_RAM_RESPONDER -- requirements
Module: dbus_ram_responder

---
 rtl/dbus_ram_responder_if.sv | 23 ++
 rtl/dbus_ram_responder.sv | 129 ++++++++++++
 tb/tb_dbus_ram_responder.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_ram_responder_if.sv
// Simple request/grant data bus with a single-beat response channel.
// Handshake: an access is accepted on the clock edge that ends a cycle with req=1 and gnt=1;
// its response is the single cycle with rvalid=1, and rdata is only meaningful in that cycle.
interface data_bus;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dbus_ram_responder.sv
// Single-outstanding RAM responder on a req/gnt data bus.
// Grant and response delays are set by GNT_WAIT and RESP_WAIT.
module dbus_ram_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int GNT_WAIT  = 0,
    parameter int RESP_WAIT = 0
) (
    input logic    clk,
    input logic    rst_n,
    data_bus.slave dbus
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [3:0]  GNT_LOAD  = 4'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
    localparam logic [3:0]  RESP_LOAD = 4'((RESP_WAIT > 0) ? RESP_WAIT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic             gnt_c;
    logic             grant;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      resp_q;
    logic [31:0]      mem [MEM_WORDS];
    logic             unused_addr_bits;

    // Byte offset bits never select anything; addresses are word aligned.
    assign unused_addr_bits = ^dbus.addr[1:0];

    assign idx      = dbus.addr[IDX_W+1:2];
    assign in_range = (dbus.addr[31:IDX_W+2] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_c     = 1'b0;
        case (state)
            IDLE: begin
                if (dbus.req) begin
                    if (GNT_WAIT == 0) begin
                        gnt_c = 1'b1;
                    end else begin
                        state_nxt = WAIT_GNT;
                        cnt_nxt   = GNT_LOAD;
                    end
                end
            end
            WAIT_GNT: begin
                if (!dbus.req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    gnt_c = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESPOND;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESPOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase

        // The grant edge launches the response wait, whichever state granted.
        if (gnt_c) begin
            if (RESP_WAIT == 0) begin
                state_nxt = RESPOND;
                cnt_nxt   = 4'd0;
            end else begin
                state_nxt = WAIT_RESP;
                cnt_nxt   = RESP_LOAD;
            end
        end
    end

    // Reset gating keeps gnt low (and memory untouched) while rst_n is held low.
    assign grant       = gnt_c & rst_n;
    assign dbus.gnt    = grant;
    assign dbus.rvalid = (state == RESPOND);
    assign dbus.rdata  = (state == RESPOND) ? resp_q : 32'd0;

    always_ff @(posedge clk) begin
        if (grant && dbus.we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (dbus.be[i]) begin
                    mem[idx][8*i +: 8] <= dbus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= 32'd0;
        end else if (grant) begin
            resp_q <= (!dbus.we && in_range) ? mem[idx] : 32'd0;
        end
    end

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Directed bench for dbus_ram_responder: three instances cover default timing,
// GNT_WAIT=3/RESP_WAIT=2, and RESP_WAIT=4 with reset in the middle of an access.
module tb_dbus_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rstn_v   [3];
    logic        req_v    [3];
    logic        we_v     [3];
    logic [3:0]  be_v     [3];
    logic [31:0] addr_v   [3];
    logic [31:0] wdata_v  [3];
    logic        gnt_v    [3];
    logic        rvalid_v [3];
    logic [31:0] rdata_v  [3];

    data_bus bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_conn
        assign bus[g].req   = req_v[g];
        assign bus[g].we    = we_v[g];
        assign bus[g].be    = be_v[g];
        assign bus[g].addr  = addr_v[g];
        assign bus[g].wdata = wdata_v[g];
        assign gnt_v[g]     = bus[g].gnt;
        assign rvalid_v[g]  = bus[g].rvalid;
        assign rdata_v[g]   = bus[g].rdata;
    end

    dbus_ram_responder u_d (
        .clk  (clk),
        .rst_n(rstn_v[0]),
        .dbus (bus[0])
    );

    dbus_ram_responder #(.MEM_WORDS(64), .GNT_WAIT(3), .RESP_WAIT(2)) u_g (
        .clk  (clk),
        .rst_n(rstn_v[1]),
        .dbus (bus[1])
    );

    dbus_ram_responder #(.MEM_WORDS(64), .RESP_WAIT(4)) u_r (
        .clk  (clk),
        .rst_n(rstn_v[2]),
        .dbus (bus[2])
    );

    // Driver: one access on instance s; reports grant cycle (1 = same cycle as req),
    // cycles from grant edge to first rvalid, rvalid count and response data.
    task automatic access(input int s, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d,
                          output int gnt_cyc, output int rv_cyc, output int rv_cnt,
                          output logic [31:0] rd);
        gnt_cyc = -1;
        rv_cyc  = -1;
        rv_cnt  = 0;
        rd      = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        req_v[s] = 1'b1; we_v[s] = w; be_v[s] = b; addr_v[s] = a; wdata_v[s] = d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (gnt_v[s]) begin
                gnt_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_v[s] = 1'b0; we_v[s] = 1'b0; be_v[s] = 4'h0; addr_v[s] = 32'd0; wdata_v[s] = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rvalid_v[s]) begin
                rv_cnt++;
                if (rv_cyc < 0) begin
                    rv_cyc = k;
                    rd     = rdata_v[s];
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rstn_v[i] = 1'b0; req_v[i] = 1'b1; we_v[i] = 1'b0; be_v[i] = 4'hF;
            addr_v[i] = 32'h10; wdata_v[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (gnt_v[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_gnt[%0d]: got %b expected 0", i, gnt_v[i]);
            end
            n_tests++;
            if (rvalid_v[i] !== 1'b0) begin
                n_fail++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", i, rvalid_v[i]);
            end
            n_tests++;
            if (rdata_v[i] !== 32'd0) begin
                n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", i, rdata_v[i]);
            end
        end
        n_tests++;
        if (u_d.cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", u_d.cnt);
        end
        for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rstn_v[i] = 1'b1;
    endtask

    task automatic test_write_read();
        int gc, rc, rn;
        logic [31:0] rd;
        access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, gc, rc, rn, rd);
        n_tests++;
        if (gc !== 1 || rc !== 1 || rn !== 1) begin
            n_fail++; $display("FAIL wr_timing: got gnt=%0d rv=%0d n=%0d expected 1 1 1", gc, rc, rn);
        end
        n_tests++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL wr_rdata: got %h expected 00000000", rd);
        end
        access(0, 1'b0, 4'h0, 32'h10, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (gc !== 1 || rc !== 1 || rn !== 1) begin
            n_fail++; $display("FAIL rd_timing: got gnt=%0d rv=%0d n=%0d expected 1 1 1", gc, rc, rn);
        end
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd);
        end
        n_tests++;
        if (rdata_v[0] !== 32'd0) begin
            n_fail++; $display("FAIL idle_rdata: got %h expected 0", rdata_v[0]);
        end
    endtask

    task automatic test_byte_lane();
        int gc, rc, rn;
        logic [31:0] rd;
        access(0, 1'b1, 4'h2, 32'h11, 32'h0000_AA00, gc, rc, rn, rd);
        access(0, 1'b0, 4'h0, 32'h10, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (rd !== 32'hDEAD_AAEF) begin
            n_fail++; $display("FAIL byte_lane: got %h expected deadaaef", rd);
        end
    endtask

    task automatic test_out_of_range();
        int gc, rc, rn;
        logic [31:0] rd;
        access(0, 1'b1, 4'hF, 32'h0, 32'h1234_5678, gc, rc, rn, rd);
        access(0, 1'b0, 4'hF, 32'h0000_1000, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (rn !== 1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL oor_read: got n=%0d data=%h expected 1 00000000", rn, rd);
        end
        access(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, gc, rc, rn, rd);
        n_tests++;
        if (gc !== 1 || rn !== 1) begin
            n_fail++; $display("FAIL oor_write_ack: got gnt=%0d n=%0d expected 1 1", gc, rn);
        end
        access(0, 1'b0, 4'h0, 32'h0, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL oor_alias_word0: got %h expected 12345678", rd);
        end
        access(0, 1'b0, 4'h0, 32'h10, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (rd !== 32'hDEAD_AAEF) begin
            n_fail++; $display("FAIL oor_word4: got %h expected deadaaef", rd);
        end
    endtask

    task automatic test_gnt_wait();
        int gc, rc, rn, ng, nr;
        logic [31:0] rd;
        access(1, 1'b1, 4'hF, 32'h8, 32'hA5A5_0F0F, gc, rc, rn, rd);
        access(1, 1'b0, 4'h0, 32'h8, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (gc !== 4) begin
            n_fail++; $display("FAIL gw_gnt_cycle: got %0d expected 4", gc);
        end
        n_tests++;
        if (rc !== 3 || rn !== 1) begin
            n_fail++; $display("FAIL gw_resp: got rv=%0d n=%0d expected 3 1", rc, rn);
        end
        n_tests++;
        if (rd !== 32'hA5A5_0F0F) begin
            n_fail++; $display("FAIL gw_rdata: got %h expected a5a50f0f", rd);
        end
        // Abandon a write before its grant: no access, no response.
        @(posedge clk); #1;
        req_v[1] = 1'b1; we_v[1] = 1'b1; be_v[1] = 4'hF; addr_v[1] = 32'h8; wdata_v[1] = 32'd0;
        ng = 0; nr = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (gnt_v[1]) ng++;
            @(posedge clk); #1;
        end
        req_v[1] = 1'b0; we_v[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt_v[1]) ng++;
            if (rvalid_v[1]) nr++;
        end
        n_tests++;
        if (ng !== 0 || nr !== 0) begin
            n_fail++; $display("FAIL gw_abort: got gnt=%0d rvalid=%0d expected 0 0", ng, nr);
        end
        access(1, 1'b0, 4'h0, 32'h8, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (rd !== 32'hA5A5_0F0F) begin
            n_fail++; $display("FAIL gw_abort_mem: got %h expected a5a50f0f", rd);
        end
    endtask

    task automatic test_reset_mid();
        int gc, rc, rn, nr;
        logic [31:0] rd;
        access(2, 1'b1, 4'hF, 32'h20, 32'h1122_3344, gc, rc, rn, rd);
        n_tests++;
        if (rc !== 5 || rn !== 1) begin
            n_fail++; $display("FAIL rw_latency: got rv=%0d n=%0d expected 5 1", rc, rn);
        end
        // Read granted, then reset two cycles after the grant edge.
        @(posedge clk); #1;
        req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 32'h20;
        @(negedge clk);
        n_tests++;
        if (gnt_v[2] !== 1'b1) begin
            n_fail++; $display("FAIL rw_mid_gnt: got %b expected 1", gnt_v[2]);
        end
        @(posedge clk); #1;
        req_v[2] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rstn_v[2] = 1'b0; req_v[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (gnt_v[2] !== 1'b0 || rvalid_v[2] !== 1'b0) begin
                n_fail++; $display("FAIL rw_in_reset: got gnt=%b rvalid=%b expected 0 0", gnt_v[2], rvalid_v[2]);
            end
            @(posedge clk); #1;
        end
        req_v[2] = 1'b0; rstn_v[2] = 1'b1;
        nr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rvalid_v[2]) nr++;
        end
        n_tests++;
        if (nr !== 0) begin
            n_fail++; $display("FAIL rw_no_rvalid: got %0d expected 0", nr);
        end
        // Write granted immediately before reset must persist.
        @(posedge clk); #1;
        req_v[2] = 1'b1; we_v[2] = 1'b1; be_v[2] = 4'hF; addr_v[2] = 32'h24; wdata_v[2] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rstn_v[2] = 1'b0; req_v[2] = 1'b0; we_v[2] = 1'b0;
        @(posedge clk); #1;
        rstn_v[2] = 1'b1;
        access(2, 1'b0, 4'h0, 32'h24, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL rw_write_kept: got %h expected cafef00d", rd);
        end
        access(2, 1'b0, 4'h0, 32'h20, 32'd0, gc, rc, rn, rd);
        n_tests++;
        if (gc !== 1 || rc !== 5 || rn !== 1 || rd !== 32'h1122_3344) begin
            n_fail++; $display("FAIL rw_after_reset: got gnt=%0d rv=%0d n=%0d data=%h expected 1 5 1 11223344",
                               gc, rc, rn, rd);
        end
    endtask

    task automatic test_back_to_back();
        int ng, nr;
        ng = 0; nr = 0;
        @(posedge clk); #1;
        req_v[0] = 1'b1; we_v[0] = 1'b0; be_v[0] = 4'h0; addr_v[0] = 32'h10;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (gnt_v[0]) ng++;
            if (rvalid_v[0]) nr++;
            n_tests++;
            if (gnt_v[0] !== ((c % 2) == 0) || rvalid_v[0] !== ((c % 2) == 1)) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got gnt=%b rvalid=%b expected %b %b",
                                   c, gnt_v[0], rvalid_v[0], (c % 2) == 0, (c % 2) == 1);
            end
            n_tests++;
            if (rdata_v[0] !== (((c % 2) == 1) ? 32'hDEAD_AAEF : 32'd0)) begin
                n_fail++; $display("FAIL b2b_rdata%0d: got %h", c, rdata_v[0]);
            end
            @(posedge clk); #1;
        end
        req_v[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (gnt_v[0]) ng++;
            if (rvalid_v[0]) nr++;
        end
        n_tests++;
        if (ng !== 4 || nr !== 4) begin
            n_fail++; $display("FAIL b2b_counts: got gnt=%0d rvalid=%0d expected 4 4", ng, nr);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lane();
        test_out_of_range();
        test_gnt_wait();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
